// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Provides the op encoding used by the control unit and the op field width.
// Codes not listed here (3'b110, 3'b111) are treated as HOLD by the sequencer.
package pc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
  localparam logic [OP_W-1:0] OP_INC    = 3'b001;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'b010;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'b011;
  localparam logic [OP_W-1:0] OP_CALL   = 3'b100;
  localparam logic [OP_W-1:0] OP_RET    = 3'b101;

endpackage : pc_pkg

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO for the pc sequencer.
// Ports: clk, rst (async, active-high), push/din write a new entry, pop drops
// the top entry, top shows the newest entry (0 when empty), empty/full flags.
// Push when full and pop when empty are ignored; the parent flags the error.
module pc_ret_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty,
  output logic                full
);

  // Pointer counts held entries, 0..STACK_DEPTH.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  // Storage is rounded up to a power of two so the pointer indexes it at
  // exactly its own width; only the first STACK_DEPTH slots are ever written.
  localparam int MEM_N = 1 << SP_W;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  logic [SP_W-1:0]     sp;
  logic [SP_W-1:0]     sp_m1;
  logic [PC_WIDTH-1:0] mem [MEM_N];
  logic                do_push;
  logic                do_pop;

  assign empty   = (sp == '0);
  assign full    = (sp == SP_MAX);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign sp_m1   = sp - 1'b1;
  assign top     = empty ? '0 : mem[sp_m1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp <= sp_m1;
    end
  end

  // Entry contents need no reset: they are only visible through top when
  // the pointer says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp] <= din;
    end
  end

endmodule : pc_ret_stack

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump, conditional relative branch,
// call/return via an internal return stack, sticky overflow/underflow err.
// Ports: clk, rst (async, active-high), en, op, target, offset, cond, clr_err
// in; pc, ret_top, stack_empty, stack_full, err out. All outputs registered.
// Optional macro PC_TRACE_EN adds pc_changed, a one-cycle pulse after any
// edge where pc took a non-sequential value (JUMP, taken BRANCH, CALL, RET).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int OFF_WIDTH   = 6,
  parameter int STEP        = 1,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [OP_W-1:0]      op,
  input  logic [PC_WIDTH-1:0]  target,
  input  logic [OFF_WIDTH-1:0] offset,
  input  logic                 cond,
  input  logic                 clr_err,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  ret_top,
  output logic                 stack_empty,
  output logic                 stack_full,
  output logic                 err
`ifdef PC_TRACE_EN
  ,
  output logic                 pc_changed
`endif
);

  localparam logic [PC_WIDTH-1:0] STEP_V  = PC_WIDTH'(STEP);
  localparam logic [PC_WIDTH-1:0] RESET_V = PC_WIDTH'(RESET_VEC);

  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] off_ext;
  logic                push;
  logic                pop;
  logic                err_set;
  logic                nonseq;

  // Modular arithmetic: plain PC_WIDTH-bit adds drop the carry, giving the
  // silent wrap for both increment and branch.
  assign pc_seq  = pc + STEP_V;
  assign off_ext = PC_WIDTH'($signed(offset));

  pc_ret_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_seq),
    .top   (ret_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    nonseq  = 1'b0;
    if (en) begin
      case (op)
        OP_INC: begin
          pc_nxt = pc_seq;
        end
        OP_JUMP: begin
          pc_nxt = target;
          nonseq = 1'b1;
        end
        OP_BRANCH: begin
          if (cond) begin
            pc_nxt = pc + off_ext;
            nonseq = 1'b1;
          end else begin
            pc_nxt = pc_seq;
          end
        end
        OP_CALL: begin
          if (stack_full) begin
            err_set = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = target;
            nonseq = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_set = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = ret_top;
            nonseq = 1'b1;
          end
        end
        default: begin
          pc_nxt = pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_V;
    end else begin
      pc <= pc_nxt;
    end
  end

  // A new error takes priority over a same-cycle clear; clear works even
  // while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

`ifdef PC_TRACE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_changed <= 1'b0;
    end else begin
      pc_changed <= nonseq;
    end
  end
`else
  // Only the trace output consumes this flag.
  logic unused_nonseq;
  assign unused_nonseq = nonseq;
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] op;
  logic [7:0] target;
  logic [5:0] offset;
  logic       cond;
  logic       clr_err;
  logic [7:0] pc;
  logic [7:0] ret_top;
  logic       stack_empty;
  logic       stack_full;
  logic       err;
`ifdef PC_TRACE_EN
  logic       pc_changed;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] top;
    logic       empty;
    logic       full;
    logic       err;
    logic       chg;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(
    .PC_WIDTH    (8),
    .OFF_WIDTH   (6),
    .STEP        (1),
    .STACK_DEPTH (4),
    .RESET_VEC   ('h10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .cond        (cond),
    .clr_err     (clr_err),
    .pc          (pc),
    .ret_top     (ret_top),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .err         (err)
`ifdef PC_TRACE_EN
    ,
    .pc_changed  (pc_changed)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got 0x%02h, expected 0x%02h", name, field, act, expv);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    cmp(e.name, "pc", pc, e.pc);
    cmp(e.name, "ret_top", ret_top, e.top);
    cmp(e.name, "stack_empty", {7'd0, stack_empty}, {7'd0, e.empty});
    cmp(e.name, "stack_full", {7'd0, stack_full}, {7'd0, e.full});
    cmp(e.name, "err", {7'd0, err}, {7'd0, e.err});
`ifdef PC_TRACE_EN
    cmp(e.name, "pc_changed", {7'd0, pc_changed}, {7'd0, e.chg});
`endif
  endtask

  // Monitor: every active edge presents a result; pop the expectation the
  // driver queued for that edge and compare just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) cmp_all(sb.pop_front());
    end
  end

  // Drive one op at the falling edge and queue the result expected after
  // the following rising edge.
  task automatic step(input string name, input logic e, input logic [2:0] o,
                      input logic [7:0] t, input logic [5:0] off, input logic c,
                      input logic clr, input logic [7:0] xpc, input logic [7:0] xtop,
                      input logic xe, input logic xf, input logic xerr, input logic xchg);
    exp_t x;
    @(negedge clk);
    en = e; op = o; target = t; offset = off; cond = c; clr_err = clr;
    x.name = name; x.pc = xpc; x.top = xtop; x.empty = xe; x.full = xf;
    x.err = xerr; x.chg = xchg;
    sb.push_back(x);
    @(posedge clk);
  endtask

  initial begin
    exp_t r;
    rst = 1'b1; en = 1'b0; op = OP_HOLD; target = '0; offset = '0;
    cond = 1'b0; clr_err = 1'b0;
    #12;
    r.name = "reset0"; r.pc = 8'h10; r.top = 8'h00; r.empty = 1'b1;
    r.full = 1'b0; r.err = 1'b0; r.chg = 1'b0;
    cmp_all(r);
    @(negedge clk); rst = 1'b0;

    // Build up state, then reset asynchronously in the middle of a cycle.
    step("ret_empty0", 1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h10, 8'h00, 1, 0, 1, 0);
    step("jump33",     1, OP_JUMP, 8'h33, 6'd0, 0, 0, 8'h33, 8'h00, 1, 0, 1, 1);
    step("call50",     1, OP_CALL, 8'h50, 6'd0, 0, 0, 8'h50, 8'h34, 0, 0, 1, 1);
    @(negedge clk);
    en = 1'b1; op = OP_JUMP; target = 8'h77;
    #2 rst = 1'b1;
    #1;
    r.name = "reset_mid";
    cmp_all(r);
    @(negedge clk); en = 1'b0; rst = 1'b0;

    // Wrap
    step("jumpFE", 1, OP_JUMP, 8'hFE, 6'd0, 0, 0, 8'hFE, 8'h00, 1, 0, 0, 1);
    step("incFF",  1, OP_INC,  8'h00, 6'd0, 0, 0, 8'hFF, 8'h00, 1, 0, 0, 0);
    step("inc00",  1, OP_INC,  8'h00, 6'd0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);

    // Branch
    step("jump20",   1, OP_JUMP,   8'h20, 6'd0,       0, 0, 8'h20, 8'h00, 1, 0, 0, 1);
    step("br_m4",    1, OP_BRANCH, 8'h00, 6'b111100,  1, 0, 8'h1C, 8'h00, 1, 0, 0, 1);
    step("br_nt",    1, OP_BRANCH, 8'h00, 6'b111100,  0, 0, 8'h1D, 8'h00, 1, 0, 0, 0);
    step("br_p31",   1, OP_BRANCH, 8'h00, 6'b011111,  1, 0, 8'h3C, 8'h00, 1, 0, 0, 1);
    step("br_m32",   1, OP_BRANCH, 8'h00, 6'b100000,  1, 0, 8'h1C, 8'h00, 1, 0, 0, 1);

    // Call/return, including a return address that wraps
    step("jump05",   1, OP_JUMP, 8'h05, 6'd0, 0, 0, 8'h05, 8'h00, 1, 0, 0, 1);
    step("call40",   1, OP_CALL, 8'h40, 6'd0, 0, 0, 8'h40, 8'h06, 0, 0, 0, 1);
    step("ret06",    1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h06, 8'h00, 1, 0, 0, 1);
    step("jumpFF",   1, OP_JUMP, 8'hFF, 6'd0, 0, 0, 8'hFF, 8'h00, 1, 0, 0, 1);
    step("call12",   1, OP_CALL, 8'h12, 6'd0, 0, 0, 8'h12, 8'h00, 0, 0, 0, 1);
    step("ret00",    1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    step("jump06",   1, OP_JUMP, 8'h06, 6'd0, 0, 0, 8'h06, 8'h00, 1, 0, 0, 1);

    // Overflow / underflow
    step("callA",    1, OP_CALL, 8'h10, 6'd0, 0, 0, 8'h10, 8'h07, 0, 0, 0, 1);
    step("callB",    1, OP_CALL, 8'h20, 6'd0, 0, 0, 8'h20, 8'h11, 0, 0, 0, 1);
    step("callC",    1, OP_CALL, 8'h30, 6'd0, 0, 0, 8'h30, 8'h21, 0, 0, 0, 1);
    step("callD",    1, OP_CALL, 8'h40, 6'd0, 0, 0, 8'h40, 8'h31, 0, 1, 0, 1);
    step("call_ovf", 1, OP_CALL, 8'h99, 6'd0, 0, 0, 8'h40, 8'h31, 0, 1, 1, 0);
    step("retD",     1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h31, 8'h21, 0, 0, 1, 1);
    step("retC",     1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h21, 8'h11, 0, 0, 1, 1);
    step("retB",     1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h11, 8'h07, 0, 0, 1, 1);
    step("retA",     1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h07, 8'h00, 1, 0, 1, 1);
    step("ret_unf",  1, OP_RET,  8'h00, 6'd0, 0, 0, 8'h07, 8'h00, 1, 0, 1, 0);
    step("clr_en0",  0, OP_HOLD, 8'h00, 6'd0, 0, 1, 8'h07, 8'h00, 1, 0, 0, 0);
    step("set_wins", 1, OP_RET,  8'h00, 6'd0, 0, 1, 8'h07, 8'h00, 1, 0, 1, 0);
    step("clr2",     1, OP_HOLD, 8'h00, 6'd0, 0, 1, 8'h07, 8'h00, 1, 0, 0, 0);

    // Enable and illegal ops
    step("en0_jump", 0, OP_JUMP, 8'hAA, 6'd0, 0, 0, 8'h07, 8'h00, 1, 0, 0, 0);
    step("en0_call", 0, OP_CALL, 8'hAA, 6'd0, 0, 0, 8'h07, 8'h00, 1, 0, 0, 0);
    step("en0_inc",  0, OP_INC,  8'hAA, 6'd0, 0, 0, 8'h07, 8'h00, 1, 0, 0, 0);
    step("op111",    1, 3'b111,  8'hAA, 6'd0, 1, 0, 8'h07, 8'h00, 1, 0, 0, 0);
    step("op110",    1, 3'b110,  8'hAA, 6'd0, 1, 0, 8'h07, 8'h00, 1, 0, 0, 0);
    step("hold",     1, OP_HOLD, 8'hAA, 6'd0, 1, 0, 8'h07, 8'h00, 1, 0, 0, 0);
    step("jumpAA",   1, OP_JUMP, 8'hAA, 6'd0, 0, 0, 8'hAA, 8'h00, 1, 0, 0, 1);
    step("incAB",    1, OP_INC,  8'h00, 6'd0, 0, 0, 8'hAB, 8'h00, 1, 0, 0, 0);

    @(negedge clk);
    en = 1'b0; op = OP_HOLD;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule : tb_pc_sequencer
